// File: rtl/apb_master_if.sv
// Command, response and APB signal bundle for apb_master.
// The master modport is the requester's view; the slave modport is the bus/agent view.
interface apb_master_if #(
    parameter int unsigned PDATA_SIZE = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic                      cmd_write;
    logic [PDATA_SIZE-1:0]     cmd_addr;
    logic [PDATA_SIZE-1:0]     cmd_wdata;
    logic [PDATA_SIZE/8-1:0]   cmd_strb;
    logic [2:0]                cmd_prot;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [PDATA_SIZE-1:0]     rsp_rdata;
    logic                      rsp_slverr;
    logic                      rsp_timeout;

    logic                      PSEL;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [2:0]                PPROT;
    logic [PDATA_SIZE/8-1:0]   PSTRB;
    logic [PDATA_SIZE-1:0]     PADDR;
    logic [PDATA_SIZE-1:0]     PWDATA;
    logic [PDATA_SIZE-1:0]     PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        input  rsp_ready,
        output PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
        output rsp_ready,
        input  PSEL, PENABLE, PWRITE, PPROT, PSTRB, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_master.sv
// APB3/APB4 requester: one command at a time through SETUP/ACCESS with a bounded
// PREADY wait, result returned through a single-entry response slot.
module apb_master #(
    parameter int unsigned PDATA_SIZE     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic          PCLK,
    input  logic          PRESET,
    apb_master_if.master  bus
);
    localparam int unsigned StrbWidth = PDATA_SIZE / 8;
    localparam int unsigned CntWidth  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                  state_q, state_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    pwrite_q, pwrite_d;
    logic [2:0]              pprot_q, pprot_d;
    logic [StrbWidth-1:0]    pstrb_q, pstrb_d;
    logic [PDATA_SIZE-1:0]   paddr_q, paddr_d;
    logic [PDATA_SIZE-1:0]   pwdata_q, pwdata_d;
    logic [CntWidth-1:0]     cnt_q, cnt_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [PDATA_SIZE-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_slverr_q, rsp_slverr_d;
    logic                    rsp_timeout_q, rsp_timeout_d;

    logic                    cmd_ready;
    logic [CntWidth-1:0]     cnt_inc;
    logic                    timeout_hit;

    // The slot must be empty or draining this cycle before a new transfer may start.
    assign cmd_ready   = !PRESET && (state_q == StIdle) && (!rsp_valid_q || bus.rsp_ready);
    assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CntWidth'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CntLimit);

    always_comb begin
        state_d       = state_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        pprot_d       = pprot_q;
        pstrb_d       = pstrb_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        cnt_d         = cnt_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_slverr_d  = rsp_slverr_q;
        rsp_timeout_d = rsp_timeout_q;

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (bus.cmd_valid && cmd_ready) begin
                    state_d   = StSetup;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = bus.cmd_write;
                    pprot_d   = bus.cmd_prot;
                    paddr_d   = bus.cmd_addr;
                    pstrb_d   = bus.cmd_write ? bus.cmd_strb : '0;
                    pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
                    cnt_d     = '0;
                end
            end
            StSetup: begin
                state_d   = StAccess;
                penable_d = 1'b1;
            end
            StAccess: begin
                if (bus.PREADY) begin
                    state_d       = StIdle;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : bus.PRDATA;
                    rsp_slverr_d  = bus.PSLVERR;
                    rsp_timeout_d = 1'b0;
                end else if (timeout_hit) begin
                    state_d       = StIdle;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_slverr_d  = 1'b1;
                    rsp_timeout_d = 1'b1;
                    cnt_d         = cnt_inc;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q       <= StIdle;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            pprot_q       <= '0;
            pstrb_q       <= '0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            cnt_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_slverr_q  <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            pprot_q       <= pprot_d;
            pstrb_q       <= pstrb_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            cnt_q         <= cnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_slverr_q  <= rsp_slverr_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = cmd_ready;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_slverr  = rsp_slverr_q;
    assign bus.rsp_timeout = rsp_timeout_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PPROT       = pprot_q;
    assign bus.PSTRB       = pstrb_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: reactive APB slave with programmable wait
// states, directed scenarios and a randomized run against a transaction-level model.
module tb_apb_master;
    localparam int unsigned T = 4;

    logic PCLK = 1'b0;
    logic PRESET;
    always #5 PCLK = ~PCLK;

    apb_master_if #(.PDATA_SIZE(32)) bus ();

    apb_master #(
        .PDATA_SIZE     (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    // Slave behaviour for the current transfer.
    int          slave_waits = 0;
    logic [31:0] slave_rdata = '0;
    logic        slave_err   = 1'b0;
    int          acc_n       = 0;

    always @(negedge PCLK) begin
        if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
            bus.PREADY  = (acc_n >= slave_waits);
            bus.PRDATA  = bus.PREADY ? slave_rdata : $urandom;
            bus.PSLVERR = bus.PREADY ? slave_err : 1'($urandom % 2);
            acc_n++;
        end else begin
            // Garbage outside ACCESS must be ignored.
            acc_n       = 0;
            bus.PREADY  = 1'($urandom % 2);
            bus.PRDATA  = $urandom;
            bus.PSLVERR = 1'($urandom % 2);
        end
    end

    // Observations from the last transfer.
    int          o_lat, o_acc;
    logic        o_hold, o_psel_rsp;
    logic [31:0] o_rdata;
    logic        o_slverr, o_timeout;
    logic        s_psel, s_penable, s_pwrite;
    logic [2:0]  s_pprot;
    logic [3:0]  s_pstrb;
    logic [31:0] s_paddr, s_pwdata;

    // Transaction-level reference: latency in cycles after accept, ACCESS cycles, response.
    function automatic void model(input logic wr, input int waits, input logic [31:0] rd,
                                  input logic err, output int lat, output int acc,
                                  output logic [31:0] e_rdata, output logic e_err,
                                  output logic e_to);
        e_to = (T != 0) && (waits >= int'(T));
        if (e_to) begin
            lat = T + 2; acc = T; e_rdata = 0; e_err = 1'b1;
        end else begin
            lat = waits + 3; acc = waits + 1; e_rdata = wr ? 32'h0 : rd; e_err = err;
        end
    endfunction

    // Called and returns at a negedge; returns in the cycle rsp_valid is first seen.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input logic [31:0] rdata, input logic err);
        int   guard;
        logic done;
        slave_waits   = waits;
        slave_rdata   = rdata;
        slave_err     = err;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
        bus.cmd_strb  = strb;
        bus.cmd_prot  = prot;
        guard = 0;
        while (bus.cmd_ready !== 1'b1 && guard < 40) begin
            @(negedge PCLK);
            guard++;
        end
        o_lat = 0; o_acc = 0; o_hold = 1'b0; o_psel_rsp = 1'bx;
        if (guard >= 40) begin
            checks++; errors++;
            $display("FAIL accept_wait got cmd_ready=%b exp 1 within 40 cycles", bus.cmd_ready);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(posedge PCLK);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'($urandom % 2);
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = 4'($urandom);
        bus.cmd_prot  = 3'($urandom);
        done = 1'b0;
        while (!done && o_lat < 40) begin
            @(negedge PCLK);
            o_lat++;
            if (bus.rsp_valid === 1'b1) begin
                done       = 1'b1;
                o_rdata    = bus.rsp_rdata;
                o_slverr   = bus.rsp_slverr;
                o_timeout  = bus.rsp_timeout;
                o_psel_rsp = bus.PSEL;
            end else if (o_lat == 1) begin
                s_psel = bus.PSEL; s_penable = bus.PENABLE; s_pwrite = bus.PWRITE;
                s_pprot = bus.PPROT; s_pstrb = bus.PSTRB; s_paddr = bus.PADDR;
                s_pwdata = bus.PWDATA;
            end else if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
                o_acc++;
                if ({bus.PADDR, bus.PWRITE, bus.PPROT, bus.PSTRB, bus.PWDATA} !==
                    {s_paddr, s_pwrite, s_pprot, s_pstrb, s_pwdata}) o_hold = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        PRESET        = 1'b1;
        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = $urandom;
        bus.cmd_wdata = $urandom;
        bus.cmd_strb  = 4'hF;
        bus.cmd_prot  = 3'h7;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PPROT, bus.PSTRB, bus.PADDR, bus.PWDATA} !== '0)
            begin errors++; $display("FAIL reset_apb got sel=%b en=%b addr=%h wdata=%h strb=%h exp all 0",
                bus.PSEL, bus.PENABLE, bus.PADDR, bus.PWDATA, bus.PSTRB); end
        checks++;
        if ({bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout} !== '0) begin
            errors++; $display("FAIL reset_rsp got valid=%b rdata=%h err=%b to=%b exp all 0",
                bus.rsp_valid, bus.rsp_rdata, bus.rsp_slverr, bus.rsp_timeout); end
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            errors++; $display("FAIL reset_cmd_ready got %b exp 0", bus.cmd_ready); end
        PRESET        = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge PCLK);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.PSEL !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got ready=%b psel=%b exp 1 0",
                bus.cmd_ready, bus.PSEL); end
    endtask

    task automatic test_zero_wait_write;
        xfer(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'h2, 0, 32'hA5A5_A5A5, 1'b0);
        checks++;
        if ({s_psel, s_penable, s_pwrite, s_pprot, s_pstrb, s_paddr, s_pwdata} !==
            {1'b1, 1'b0, 1'b1, 3'h2, 4'hF, 32'h10, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL wr_setup got sel=%b en=%b wr=%b prot=%h strb=%h addr=%h wd=%h exp 1 0 1 2 f 10 deadbeef",
                s_psel, s_penable, s_pwrite, s_pprot, s_pstrb, s_paddr, s_pwdata); end
        checks++;
        if (o_acc !== 1 || o_hold !== 1'b0) begin
            errors++; $display("FAIL wr_access got acc=%0d hold_changed=%b exp 1 0", o_acc, o_hold); end
        checks++;
        if (o_lat !== 3 || o_rdata !== 32'h0 || o_slverr !== 1'b0 || o_timeout !== 1'b0) begin
            errors++; $display("FAIL wr_rsp got lat=%0d rdata=%h err=%b to=%b exp 3 0 0 0",
                o_lat, o_rdata, o_slverr, o_timeout); end
        checks++;
        if (o_psel_rsp !== 1'b0) begin
            errors++; $display("FAIL wr_psel_drop got %b exp 0", o_psel_rsp); end
    endtask

    task automatic test_read_waits;
        xfer(1'b0, 32'h20, 32'hCAFE_F00D, 4'hF, 3'h0, 2, 32'h1234_5678, 1'b0);
        checks++;
        if (s_pstrb !== 4'h0 || s_pwdata !== 32'h0 || s_pwrite !== 1'b0 || o_hold !== 1'b0) begin
            errors++; $display("FAIL rd_ctrl got strb=%h wd=%h wr=%b hold_changed=%b exp 0 0 0 0",
                s_pstrb, s_pwdata, s_pwrite, o_hold); end
        checks++;
        if (o_lat !== 5 || o_acc !== 3 || o_rdata !== 32'h1234_5678) begin
            errors++; $display("FAIL rd_wait got lat=%0d acc=%0d rdata=%h exp 5 3 12345678",
                o_lat, o_acc, o_rdata); end
    endtask

    task automatic test_slave_error;
        xfer(1'b0, 32'h44, 32'h0, 4'h0, 3'h1, 0, 32'hFFFF_FFFF, 1'b1);
        checks++;
        if (o_slverr !== 1'b1 || o_timeout !== 1'b0 || o_rdata !== 32'hFFFF_FFFF || o_lat !== 3) begin
            errors++; $display("FAIL slverr got err=%b to=%b rdata=%h lat=%0d exp 1 0 ffffffff 3",
                o_slverr, o_timeout, o_rdata, o_lat); end
    endtask

    task automatic test_timeout;
        xfer(1'b0, 32'h80, 32'h0, 4'h0, 3'h0, 100, 32'h5555_AAAA, 1'b0);
        checks++;
        if (o_lat !== 6 || o_acc !== 4 || o_psel_rsp !== 1'b0) begin
            errors++; $display("FAIL to_timing got lat=%0d acc=%0d psel=%b exp 6 4 0",
                o_lat, o_acc, o_psel_rsp); end
        checks++;
        if (o_slverr !== 1'b1 || o_timeout !== 1'b1 || o_rdata !== 32'h0) begin
            errors++; $display("FAIL to_rsp got err=%b to=%b rdata=%h exp 1 1 0",
                o_slverr, o_timeout, o_rdata); end
        // PREADY rising on the final permitted wait cycle completes normally.
        xfer(1'b0, 32'h84, 32'h0, 4'h0, 3'h0, 3, 32'h0BAD_CAFE, 1'b0);
        checks++;
        if (o_lat !== 6 || o_timeout !== 1'b0 || o_slverr !== 1'b0 || o_rdata !== 32'h0BAD_CAFE) begin
            errors++; $display("FAIL to_edge got lat=%0d to=%b err=%b rdata=%h exp 6 0 0 0badcafe",
                o_lat, o_timeout, o_slverr, o_rdata); end
    endtask

    task automatic test_backpressure;
        logic [31:0] held;
        bus.rsp_ready = 1'b0;
        xfer(1'b0, 32'h100, 32'h0, 4'h0, 3'h0, 0, 32'h1111_2222, 1'b0);
        held = o_rdata;
        slave_waits   = 0;
        slave_rdata   = 32'h3333_4444;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h104;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            checks++;
            if (bus.cmd_ready !== 1'b0 || bus.PSEL !== 1'b0 || bus.rsp_valid !== 1'b1 ||
                bus.rsp_rdata !== held) begin
                errors++; $display("FAIL bp_stall[%0d] got ready=%b psel=%b rv=%b rdata=%h exp 0 0 1 %h",
                    i, bus.cmd_ready, bus.PSEL, bus.rsp_valid, bus.rsp_rdata, held); end
        end
        bus.rsp_ready = 1'b1;
        #1;
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got ready=%b exp 1", bus.cmd_ready); end
        @(posedge PCLK);
        #1 bus.cmd_valid = 1'b0;
        @(negedge PCLK);
        checks++;
        if (bus.PSEL !== 1'b1 || bus.PENABLE !== 1'b0 || bus.rsp_valid !== 1'b0 ||
            bus.PADDR !== 32'h104) begin
            errors++; $display("FAIL bp_second_setup got psel=%b en=%b rv=%b addr=%h exp 1 0 0 104",
                bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.PADDR); end
        repeat (2) @(negedge PCLK);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h3333_4444) begin
            errors++; $display("FAIL bp_second_rsp got rv=%b rdata=%h exp 1 33334444",
                bus.rsp_valid, bus.rsp_rdata); end
    endtask

    task automatic test_reset_mid_access;
        slave_waits   = 100;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 32'h200;
        bus.cmd_prot  = 3'h5;
        @(negedge PCLK);
        @(posedge PCLK);
        #1 bus.cmd_valid = 1'b0;
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1 PRESET = 1'b0;
        @(negedge PCLK);
        checks++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PPROT, bus.PSTRB, bus.PADDR, bus.PWDATA,
             bus.rsp_valid} !== '0 || bus.cmd_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid got psel=%b en=%b addr=%h prot=%h rv=%b ready=%b exp 0 0 0 0 0 1",
                bus.PSEL, bus.PENABLE, bus.PADDR, bus.PPROT, bus.rsp_valid, bus.cmd_ready); end
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0) begin
                errors++; $display("FAIL rst_dropped[%0d] got rv=%b psel=%b exp 0 0",
                    i, bus.rsp_valid, bus.PSEL); end
        end
        xfer(1'b1, 32'h204, 32'h7777_8888, 4'h3, 3'h1, 1, 32'h0, 1'b0);
        checks++;
        if (o_lat !== 4 || o_slverr !== 1'b0 || o_rdata !== 32'h0 || s_pstrb !== 4'h3) begin
            errors++; $display("FAIL rst_fresh got lat=%0d err=%b rdata=%h strb=%h exp 4 0 0 3",
                o_lat, o_slverr, o_rdata, s_pstrb); end
    endtask

    // Random transfers back to back; rsp_ready held high so each response drains
    // in the same cycle the next command is accepted.
    task automatic test_random;
        logic        wr, err, e_err, e_to;
        logic [31:0] addr, wdata, rd, e_rdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits, e_lat, e_acc;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom % 2); err = 1'($urandom % 2);
            addr = $urandom; wdata = $urandom; rd = $urandom;
            strb = 4'($urandom); prot = 3'($urandom);
            waits = int'($urandom_range(0, 6));
            model(wr, waits, rd, err, e_lat, e_acc, e_rdata, e_err, e_to);
            xfer(wr, addr, wdata, strb, prot, waits, rd, err);
            checks++;
            if ({s_psel, s_penable, s_pwrite, s_pprot, s_pstrb, s_paddr, s_pwdata} !==
                {1'b1, 1'b0, wr, prot, wr ? strb : 4'h0, addr, wr ? wdata : 32'h0}) begin
                errors++; $display("FAIL rand_setup[%0d] got sel=%b en=%b wr=%b prot=%h strb=%h addr=%h wd=%h exp wr=%b prot=%h addr=%h",
                    i, s_psel, s_penable, s_pwrite, s_pprot, s_pstrb, s_paddr, s_pwdata, wr, prot, addr); end
            checks++;
            if (o_lat !== e_lat || o_acc !== e_acc || o_hold !== 1'b0 || o_psel_rsp !== 1'b0) begin
                errors++; $display("FAIL rand_timing[%0d] got lat=%0d acc=%0d hold=%b psel=%b exp %0d %0d 0 0",
                    i, o_lat, o_acc, o_hold, o_psel_rsp, e_lat, e_acc); end
            checks++;
            if (o_rdata !== e_rdata || o_slverr !== e_err || o_timeout !== e_to) begin
                errors++; $display("FAIL rand_rsp[%0d] got rdata=%h err=%b to=%b exp %h %b %b",
                    i, o_rdata, o_slverr, o_timeout, e_rdata, e_err, e_to); end
            if ($urandom % 3 == 0) @(negedge PCLK);
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_read_waits();
        test_slave_error();
        test_timeout();
        test_backpressure();
        test_reset_mid_access();
        test_random();
        repeat (3) @(negedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish exp finish before 200000");
        $fatal(1);
    end
endmodule

// File: doc/apb_master.md
# apb_master

APB requester (master) for the AHB-to-APB bridge datapath: accepts one command at a time on a valid/ready command port and drives a single APB3/APB4 transfer. It runs the SETUP and ACCESS phases and waits on PREADY, with a bounded wait timeout. The captured read data and error status are returned on a valid/ready response port. It is the counterpart of the APB slave side that the bench's slave driver and monitor model.

## Interface
- PDATA_SIZE, 32: width of PADDR, PWDATA and PRDATA; PSTRB is PDATA_SIZE/8 bits wide.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the timeout.

Ports:
- PCLK  in  1  clock; all logic is on the rising edge.
- PRESET  in  1  synchronous, active-high reset; one clock, reset synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  PDATA_SIZE  transfer address.
- cmd_wdata  in  PDATA_SIZE  write data.
- cmd_strb  in  PDATA_SIZE/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  PDATA_SIZE  read data; 0 for writes.
- rsp_slverr  out  1  PSLVERR was sampled high, or the transfer timed out.
- rsp_timeout  out  1  transfer was aborted by the timeout.
- PSEL, PENABLE, PWRITE  out  1 each  APB control.
- PPROT  out  3  APB protection attributes.
- PSTRB  out  PDATA_SIZE/8  APB write strobes.
- PADDR, PWDATA  out  PDATA_SIZE each  APB address and write data.
- PRDATA  in  PDATA_SIZE  APB read data.
- PREADY, PSLVERR  in  1 each  APB slave handshake and error.

## Operation
- State machine with three states: IDLE, SETUP, ACCESS.
- **IDLE**
  - cmd_ready = !rsp_valid || rsp_ready, so the single response slot must be free or freeing this cycle.
  - On acceptance, register all cmd_* fields and go to SETUP.
- **SETUP** (always exactly one cycle)
  - PSEL=1, PENABLE=0.
  - PADDR, PWRITE, PPROT take the registered values.
  - PSTRB = strb on writes, all-zeros on reads.
  - PWDATA = wdata on writes, 0 on reads.
  - Go to ACCESS.
- **ACCESS**
  - PSEL=1, PENABLE=1; all address/control/data outputs held identical to SETUP.
  - While PREADY=0, increment the wait counter.
  - PREADY=1: capture PRDATA (reads only; writes return 0) and PSLVERR; set rsp_valid with rsp_timeout=0; go to IDLE.
  - Timeout: if TIMEOUT_CYCLES≠0 and the wait counter reaches TIMEOUT_CYCLES with PREADY still 0, abort. Set rsp_valid with rsp_slverr=1, rsp_timeout=1, rsp_rdata=0; go to IDLE.
  - PREADY=1 on the timeout cycle wins: it completes normally.
- Wait counter:
  - Width is clog2(TIMEOUT_CYCLES+1).
  - Cleared on entry to SETUP; saturates and never wraps.
- Response slot:
  - rsp_* are held until rsp_valid && rsp_ready.
  - A new completion can never overwrite an unconsumed response, because of the cmd_ready rule.
- PSLVERR and PRDATA are ignored unless PSEL && PENABLE && PREADY.
- Reset (PRESET=1 at a PCLK edge, in any state):
  - On the next cycle: state=IDLE, PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=0, PSTRB=0, PPROT=0.
  - rsp_valid=0, rsp_rdata=0, rsp_slverr=0, rsp_timeout=0, wait counter=0; cmd_ready=0 while PRESET=1.
  - An in-flight transfer is dropped without a response.

## Timing
- Command accepted at edge N → SETUP in cycle N+1 → ACCESS in cycle N+2.
- Zero-wait slave (PREADY=1 in N+2): rsp_valid=1 in N+3, PSEL=0 in N+3.
- Each PREADY-low ACCESS cycle adds one cycle.
- Maximum throughput is one transfer per 3 cycles; PSEL deasserts for at least one cycle between transfers.
- Timeout abort: PSEL drops in the cycle after the TIMEOUT_CYCLES-th PREADY-low ACCESS cycle; rsp_valid rises in that same cycle.
- A response consumed in the same cycle a new command is accepted is legal; rsp_valid falls while PSEL rises.
- All outputs are registered; no combinational path from APB inputs to APB outputs.

## Test plan
- **Zero-wait write**
  - Stimulus: cmd write addr 0x0000_0010, wdata 0xDEAD_BEEF, strb 0xF, prot 0x2.
  - Required: SETUP then ACCESS with the same values; rsp_valid 3 cycles after accept; rsp_slverr=0, rsp_rdata=0.
- **Read with 2 wait states**
  - Stimulus: cmd read addr 0x20; PREADY low for 2 cycles, then high with PRDATA=0x1234_5678.
  - Required: PSTRB=0 throughout; rsp_rdata=0x1234_5678; rsp_valid 5 cycles after accept.
- **Slave error**
  - Stimulus: read with PREADY=1, PSLVERR=1, PRDATA=0xFFFF_FFFF.
  - Required: rsp_slverr=1, rsp_timeout=0, rsp_rdata=0xFFFF_FFFF.
- **Timeout**
  - Stimulus: TIMEOUT_CYCLES=4, PREADY held low.
  - Required: abort after 4 wait cycles; rsp_slverr=1, rsp_timeout=1; PSEL=0 the next cycle.
  - Repeat with PREADY rising on the 4th wait cycle: normal completion.
- **Backpressure**
  - Stimulus: rsp_ready=0 after the first completion, with cmd_valid held high.
  - Required: cmd_ready=0 and no second SETUP until rsp_ready=1; then the second transfer starts in the accept+1 cycle.
- **Reset mid-ACCESS**
  - Stimulus: assert PRESET for 1 cycle during a waited read.
  - Required: next cycle all APB outputs = 0, rsp_valid=0, no response ever produced; a fresh command afterwards completes normally.
